// File: rtl/div_sched_pkg.sv
// div_sched_pkg: shared FSM state type and round-robin pick helper for div_sched.
package div_sched_pkg;

    localparam int MAX_REQ = 64;

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    typedef struct packed {
        logic        found;
        logic [31:0] idx;
    } pick_t;

    // Lowest set index at or above ptr, else lowest set index overall.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] vec, input int ptr);
        pick_t p;
        p = '0;
        for (int i = MAX_REQ - 1; i >= 0; i--) begin
            if (vec[i]) begin
                p.found = 1'b1;
                p.idx   = 32'(i);
            end
        end
        for (int i = MAX_REQ - 1; i >= 0; i--) begin
            if (vec[i] && i >= ptr) p.idx = 32'(i);
        end
        return p;
    endfunction

endpackage

// File: rtl/div_mod_serial.sv
// div_mod_serial: MSB-first bit-serial remainder of an operand by a constant divisor.
module div_mod_serial #(
    parameter int  DATA_W  = 8,
    parameter int  DIVISOR = 3,
    localparam int REM_W   = $clog2(DIVISOR),
    localparam int CNT_W   = DATA_W > 1 ? $clog2(DATA_W) : 1
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] operand,
    output logic              done,
    output logic [REM_W-1:0]  rem
);

    logic [DATA_W-1:0] op_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              active_q;
    logic [REM_W-1:0]  rem_q, rem_d;
    logic [REM_W:0]    t;

    // t < 2*DIVISOR, so one conditional subtract keeps r in range.
    always_comb begin
        t     = {rem_q, op_q[DATA_W-1]};
        rem_d = REM_W'(t >= (REM_W+1)'(DIVISOR) ? t - (REM_W+1)'(DIVISOR) : t);
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            rem_q    <= '0;
        end else if (start) begin
            op_q     <= operand;
            cnt_q    <= CNT_W'(DATA_W - 1);
            active_q <= 1'b1;
            rem_q    <= '0;
        end else if (active_q) begin
            op_q     <= op_q << 1;
            cnt_q    <= cnt_q - 1'b1;
            active_q <= cnt_q != '0;
            rem_q    <= rem_d;
        end
    end

    assign done = active_q && cnt_q == '0;
    assign rem  = rem_q;

endmodule

// File: rtl/div_sched.sv
// div_sched: round-robin scheduler sharing one bit-serial divisibility unit among requesters.
// Define DIV_SCHED_REM_EN to expose the final remainder on rsp_rem.
module div_sched
    import div_sched_pkg::*;
#(
    parameter int  DATA_W  = 8,
    parameter int  N_REQ   = 4,
    parameter int  DIVISOR = 3,
    localparam int ID_W    = $clog2(N_REQ),
    localparam int REM_W   = $clog2(DIVISOR)
) (
    input  logic                    clock,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic                    rsp_divisible,
    output logic                    busy
`ifdef DIV_SCHED_REM_EN
    ,
    output logic [REM_W-1:0]        rsp_rem
`endif
);

    if (DIVISOR < 2 || N_REQ < 2 || N_REQ > MAX_REQ) begin : g_bad_cfg
        $error("div_sched: unsupported DIVISOR or N_REQ");
    end

    state_t           state_q;
    logic [ID_W-1:0]  ptr_q, ptr_d, id_q, grant;
    logic             rsp_valid_q, busy_q, start, done;
    logic [REM_W-1:0] rem;
    pick_t            pick;

    always_comb begin
        pick      = rr_pick(MAX_REQ'(req_valid), int'(ptr_q));
        grant     = ID_W'(pick.idx);
        start     = state_q == IDLE && pick.found;
        req_ready = start ? (N_REQ'(1) << grant) : '0;
        ptr_d     = grant == ID_W'(N_REQ - 1) ? '0 : grant + 1'b1;
    end

    div_mod_serial #(
        .DATA_W  (DATA_W),
        .DIVISOR (DIVISOR)
    ) u_mod (
        .clock   (clock),
        .rst_n   (rst_n),
        .start   (start),
        .operand (req_data[grant*DATA_W +: DATA_W]),
        .done    (done),
        .rem     (rem)
    );

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (start) begin
            state_q <= CALC;
            ptr_q   <= ptr_d;
            id_q    <= grant;
            busy_q  <= 1'b1;
        end else if (state_q == CALC && done) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
        end else if (state_q == RESP && rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end
    end

    // The remainder register only changes in CALC, so it is already held through RESP.
    assign rsp_valid     = rsp_valid_q;
    assign busy          = busy_q;
    assign rsp_id        = id_q;
    assign rsp_divisible = rsp_valid_q && rem == '0;
`ifdef DIV_SCHED_REM_EN
    assign rsp_rem       = rem;
`endif

endmodule

// File: tb/tb_div_sched.sv
// tb_div_sched: table-driven checks of div_sched (DIVISOR=3) plus a DIVISOR=5 instance.
module tb_div_sched;

    logic        clock = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic        rsp_valid, rsp_ready = 1'b1, rsp_divisible, busy;
    logic [1:0]  rsp_id;

    logic [3:0]  v5 = '0;
    logic [31:0] d5 = '0;
    logic [3:0]  r5;
    logic        rv5, rdiv5, busy5;
    logic [1:0]  rid5;
`ifdef DIV_SCHED_REM_EN
    logic [1:0]  rsp_rem;
    logic [2:0]  rem5;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    div_sched #(.DATA_W(8), .N_REQ(4), .DIVISOR(3)) dut (
        .clock(clock), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_divisible(rsp_divisible), .busy(busy)
`ifdef DIV_SCHED_REM_EN
        , .rsp_rem(rsp_rem)
`endif
    );

    div_sched #(.DATA_W(8), .N_REQ(4), .DIVISOR(5)) dut5 (
        .clock(clock), .rst_n(rst_n), .req_valid(v5), .req_data(d5),
        .req_ready(r5), .rsp_valid(rv5), .rsp_ready(1'b1),
        .rsp_id(rid5), .rsp_divisible(rdiv5), .busy(busy5)
`ifdef DIV_SCHED_REM_EN
        , .rsp_rem(rem5)
`endif
    );

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [1:0]  id;
        logic        div;
        logic [1:0]  rem;
        int          stall;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int n);
        int lat;
        @(negedge clock);
        req_valid = v.valid;
        req_data  = v.data;
        rsp_ready = v.stall == 0;
        #1 chk($sformatf("v%0d req_ready", n), 32'(req_ready), 32'(4'b1 << v.id));
        @(posedge clock);
        #1 req_valid[v.id] = 1'b0;
        chk($sformatf("v%0d busy", n), 32'(busy), 32'd1);
        chk($sformatf("v%0d ready_in_calc", n), 32'(req_ready), 32'd0);
        lat = 0;
        while (!rsp_valid && lat < 30) begin
            @(posedge clock);
            lat++;
            #1;
        end
        chk($sformatf("v%0d latency", n), 32'(lat), 32'd8);
        chk($sformatf("v%0d rsp_id", n), 32'(rsp_id), 32'(v.id));
        chk($sformatf("v%0d divisible", n), 32'(rsp_divisible), 32'(v.div));
`ifdef DIV_SCHED_REM_EN
        chk($sformatf("v%0d rsp_rem", n), 32'(rsp_rem), 32'(v.rem));
`endif
        for (int c = 0; c < v.stall; c++) begin
            @(posedge clock);
            #1;
            chk($sformatf("v%0d stall%0d valid", n, c), 32'(rsp_valid), 32'd1);
            chk($sformatf("v%0d stall%0d id", n, c), 32'(rsp_id), 32'(v.id));
            chk($sformatf("v%0d stall%0d div", n, c), 32'(rsp_divisible), 32'(v.div));
            chk($sformatf("v%0d stall%0d req_ready", n, c), 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clock);
        #1 chk($sformatf("v%0d rsp_done", n), 32'({rsp_valid, busy}), 32'd0);
    endtask

    task automatic run5(input logic [7:0] d, input logic div, input logic [2:0] rem);
        int lat;
        @(negedge clock);
        v5 = 4'b0001;
        d5 = {24'd0, d};
        #1 chk("d5 req_ready", 32'(r5), 32'd1);
        @(posedge clock);
        #1 v5 = '0;
        lat = 0;
        while (!rv5 && lat < 30) begin
            @(posedge clock);
            lat++;
            #1;
        end
        chk("d5 latency", 32'(lat), 32'd8);
        chk("d5 rsp_id", 32'(rid5), 32'd0);
        chk("d5 divisible", 32'(rdiv5), 32'(div));
`ifdef DIV_SCHED_REM_EN
        chk("d5 rsp_rem", 32'(rem5), 32'(rem));
`endif
        @(posedge clock);
        #1 chk("d5 rsp_done", 32'(rv5), 32'd0);
    endtask

    initial begin
        int seen;
        // {valid, {d3,d2,d1,d0}, id, divisible, rem, stall}; ptr evolves 0,1,2,3,3,3,3,0,1,2,3,0,2,0
        tbl[0]  = '{4'b0001, 32'h000000AB, 2'd0, 1'b1, 2'd0, 0};
        tbl[1]  = '{4'b0011, 32'h000008AB, 2'd1, 1'b0, 2'd2, 20};
        tbl[2]  = '{4'b0100, 32'h00000000, 2'd2, 1'b1, 2'd0, 0};
        tbl[3]  = '{4'b0100, 32'h00010000, 2'd2, 1'b0, 2'd1, 0};
        tbl[4]  = '{4'b0100, 32'h00730000, 2'd2, 1'b0, 2'd1, 0};
        tbl[5]  = '{4'b0100, 32'h00DE0000, 2'd2, 1'b1, 2'd0, 0};
        tbl[6]  = '{4'b1000, 32'hFF000000, 2'd3, 1'b1, 2'd0, 0};
        tbl[7]  = '{4'b1111, 32'hFF0F0803, 2'd0, 1'b1, 2'd0, 0};
        tbl[8]  = '{4'b1111, 32'hFF0F0803, 2'd1, 1'b0, 2'd2, 0};
        tbl[9]  = '{4'b1111, 32'hFF0F0803, 2'd2, 1'b1, 2'd0, 0};
        tbl[10] = '{4'b1111, 32'hFF0F0803, 2'd3, 1'b1, 2'd0, 0};
        tbl[11] = '{4'b1010, 32'hFF0F0803, 2'd1, 1'b0, 2'd2, 0};
        tbl[12] = '{4'b1010, 32'hFF0F0803, 2'd3, 1'b1, 2'd0, 0};
        tbl[13] = '{4'b0110, 32'h000F0800, 2'd1, 1'b0, 2'd2, 0};

        #1 rst_n = 1'b0;
        #1;
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_id", 32'(rsp_id), 32'd0);
        chk("reset divisible", 32'(rsp_divisible), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset req_ready idle", 32'(req_ready), 32'd0);
`ifdef DIV_SCHED_REM_EN
        chk("reset rsp_rem", 32'(rsp_rem), 32'd0);
`endif
        req_valid = 4'b0100;
        #1 chk("reset req_ready pending", 32'(req_ready), 32'b0100);
        req_valid = '0;
        repeat (2) @(negedge clock);
        rst_n = 1'b1;

        for (int n = 0; n < 13; n++) run_vec(tbl[n], n);

        @(negedge clock);
        req_valid = 4'b0010;
        req_data  = 32'h00000800;
        @(posedge clock);
        #1 req_valid = '0;
        chk("pre-reset id", 32'(rsp_id), 32'd1);
        repeat (4) @(posedge clock);
        #2 rst_n = 1'b0;
        #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort rsp_id", 32'(rsp_id), 32'd0);
        chk("abort divisible", 32'(rsp_divisible), 32'd0);
        chk("abort req_ready", 32'(req_ready), 32'd0);
        @(negedge clock);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(posedge clock);
            #1 if (rsp_valid || busy) seen = 1;
        end
        chk("no rsp after abort", 32'(seen), 32'd0);
        run_vec(tbl[13], 13);

        run5(8'd115, 1'b1, 3'd0);
        run5(8'd11, 1'b0, 3'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
